// File: rtl/fetch_unit_pkg.sv
// Shared widths, opcodes, PASS word and fetch FSM encodings for the fetch stage.
// Pure definitions: no latency.
// No handshake involved.
package fetch_unit_pkg;

    localparam int BIT_INST = 16;
    localparam int SZB_INS  = 4;

    localparam logic [3:0] OP_PASS  = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'hC;
    localparam logic [3:0] OP_STORE = 4'hD;

    localparam logic [BIT_INST-1:0] PASS_WORD = 16'h0000;

    typedef enum logic [2:0] {
        ST_ISSUE  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_UPDATE = 3'd2,
        ST_INTR   = 3'd3,
        ST_FLUSH  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_imem_rf.sv
// Instruction memory register file: async clear, sync write, async read.
// Write lands at the sampling edge; read is combinational.
// No backpressure: a write is accepted every cycle it is enabled.
module imem_rf #(
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_vld,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_vld) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // A same-edge write is not visible to a fetch sampling rd_dat at that edge.
    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, instruction memory and registered instruction word to the controller.
// One word per 3 cycles (ISSUE, WAIT, UPDATE); io_cmd forwarded while in interrupt.
// No backpressure: PC steps only on controller feedback sampled in UPDATE.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int INST_W = BIT_INST,
    parameter int PC_W   = SZB_INS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              interrupt,
    input  logic              en_cnt,
    input  logic              en_offset,
    input  logic [PC_W-1:0]   pc_offset,
    input  logic              ins_we,
    input  logic [PC_W-1:0]   addr_ins,
    input  logic [INST_W-1:0] io_data,
    input  logic [INST_W-1:0] io_cmd,
    output logic [INST_W-1:0] instructions,
    output logic [PC_W-1:0]   pc,
    output logic              issue
);

    localparam logic [PC_W-1:0] PC_ONE = 1;

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [INST_W-1:0] rd_dat;
    logic [INST_W-1:0] instructions_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic              issue_nxt;

    imem_rf #(
        .AW(PC_W),
        .DW(INST_W)
    ) u_imem (
        .clock   (clock),
        .reset   (reset),
        .wr_vld  (ins_we),
        .wr_addr (addr_ins),
        .wr_dat  (io_data),
        .rd_addr (pc),
        .rd_dat  (rd_dat)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_ISSUE;
            pc           <= '0;
            instructions <= INST_W'(PASS_WORD);
            issue        <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            instructions <= instructions_nxt;
            issue        <= issue_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        instructions_nxt = INST_W'(PASS_WORD);
        issue_nxt        = 1'b0;
        pc_nxt           = pc;
        case (state)
            ST_ISSUE: begin
                instructions_nxt = rd_dat;
                issue_nxt        = 1'b1;
                state_nxt        = ST_WAIT;
            end
            ST_WAIT: begin
                state_nxt = ST_UPDATE;
            end
            ST_UPDATE: begin
                state_nxt = ST_ISSUE;
                if (en_offset) begin
                    pc_nxt = pc + pc_offset;
                end else if (en_cnt) begin
                    pc_nxt = pc + PC_ONE;
                end
            end
            ST_INTR: begin
                instructions_nxt = io_cmd;
                state_nxt        = ST_FLUSH;
            end
            ST_FLUSH: begin
                state_nxt = ST_ISSUE;
            end
            default: begin
                state_nxt = ST_ISSUE;
            end
        endcase
        // Interrupt wins from any state and abandons the in-flight PC step.
        if (interrupt) begin
            state_nxt = ST_INTR;
            pc_nxt    = pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, directed corner sequences, random run vs reference model.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        interrupt;
    logic        en_cnt;
    logic        en_offset;
    logic [3:0]  pc_offset;
    logic        ins_we;
    logic [3:0]  addr_ins;
    logic [15:0] io_data;
    logic [15:0] io_cmd;
    logic [15:0] instructions;
    logic [3:0]  pc;
    logic        issue;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: program position within the 3-cycle fetch loop plus interrupt/flush flags.
    logic [15:0] m_mem [16];
    int          m_pc;
    int          m_slot;
    bit          m_intr;
    bit          m_flush;

    typedef struct {
        logic        intr;
        logic        cnt;
        logic        off;
        logic [3:0]  poff;
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [15:0] cmd;
        logic [15:0] e_instr;
        logic        e_issue;
        logic [3:0]  e_pc;
    } vec_t;

    vec_t vq[$];

    fetch_unit dut (
        .clock        (clock),
        .reset        (reset),
        .interrupt    (interrupt),
        .en_cnt       (en_cnt),
        .en_offset    (en_offset),
        .pc_offset    (pc_offset),
        .ins_we       (ins_we),
        .addr_ins     (addr_ins),
        .io_data      (io_data),
        .io_cmd       (io_cmd),
        .instructions (instructions),
        .pc           (pc),
        .issue        (issue)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
        m_pc    = 0;
        m_slot  = 0;
        m_intr  = 0;
        m_flush = 0;
    endtask

    task automatic idle_inputs();
        interrupt = 0; en_cnt = 0; en_offset = 0; pc_offset = 0;
        ins_we = 0; addr_ins = 0; io_data = 0; io_cmd = 0;
    endtask

    // One clock edge with the currently driven inputs; checks outputs against the model.
    task automatic step(input string tag);
        logic [15:0] e_instr;
        bit          e_issue;
        int          n_pc;
        bit          s_intr, s_we;
        logic [3:0]  s_wa;
        logic [15:0] s_wd;
        e_instr = 16'h0000;
        e_issue = 0;
        if (m_intr) e_instr = io_cmd;
        else if (!m_flush && m_slot == 0) begin
            e_instr = m_mem[m_pc];
            e_issue = 1;
        end
        n_pc = m_pc;
        if (!m_intr && !m_flush && m_slot == 2 && !interrupt) begin
            if (en_offset) n_pc = (m_pc + int'(pc_offset)) % 16;
            else if (en_cnt) n_pc = (m_pc + 1) % 16;
        end
        s_intr = interrupt; s_we = ins_we; s_wa = addr_ins; s_wd = io_data;
        @(posedge clock);
        if (s_we) m_mem[s_wa] = s_wd;
        m_pc = n_pc;
        if (s_intr) begin
            m_intr = 1; m_flush = 0; m_slot = 0;
        end else if (m_intr) begin
            m_intr = 0; m_flush = 1;
        end else if (m_flush) begin
            m_flush = 0; m_slot = 0;
        end else begin
            m_slot = (m_slot + 1) % 3;
        end
        #1;
        check({tag, ".instr"}, 32'(instructions), 32'(e_instr));
        check({tag, ".issue"}, 32'(issue), 32'(e_issue));
        check({tag, ".pc"}, 32'(pc), m_pc);
    endtask

    // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
    task automatic do_reset(input string tag);
        reset = 1;
        #2;
        check({tag, ".rst_instr"}, 32'(instructions), 32'h0);
        check({tag, ".rst_issue"}, 32'(issue), 32'h0);
        check({tag, ".rst_pc"}, 32'(pc), 32'h0);
        reset = 0;
        model_reset();
    endtask

    initial begin
        int intr_left;
        idle_inputs();
        model_reset();
        reset = 1;
        #3;
        check("reset.instr", 32'(instructions), 32'h0);
        check("reset.issue", 32'(issue), 32'h0);
        check("reset.pc", 32'(pc), 32'h0);
        #9 reset = 0;

        // intr cnt off poff we wa wd cmd | instr issue pc
        vq.push_back('{1,0,0,4'd0, 0,4'd0,16'h0000,16'h1111, 16'h0000,1,4'd0});
        vq.push_back('{1,0,0,4'd0, 1,4'd0,16'hC123,16'h2222, 16'h2222,0,4'd0});
        vq.push_back('{0,0,0,4'd0, 0,4'd0,16'h0000,16'h3333, 16'h3333,0,4'd0});
        vq.push_back('{0,0,0,4'd0, 0,4'd0,16'h0000,16'h0000, 16'h0000,0,4'd0});
        vq.push_back('{0,0,0,4'd0, 0,4'd0,16'h0000,16'h0000, 16'hC123,1,4'd0});
        vq.push_back('{0,1,0,4'd0, 0,4'd0,16'h0000,16'h0000, 16'h0000,0,4'd0});
        vq.push_back('{0,1,0,4'd0, 0,4'd0,16'h0000,16'h0000, 16'h0000,0,4'd1});
        vq.push_back('{0,0,0,4'd0, 0,4'd0,16'h0000,16'h0000, 16'h0000,1,4'd1});
        vq.push_back('{0,0,0,4'd0, 0,4'd0,16'h0000,16'h0000, 16'h0000,0,4'd1});
        vq.push_back('{0,0,1,4'd13,0,4'd0,16'h0000,16'h0000, 16'h0000,0,4'd14});
        vq.push_back('{0,0,0,4'd0, 0,4'd0,16'h0000,16'h0000, 16'h0000,1,4'd14});
        vq.push_back('{0,0,1,4'd3, 0,4'd0,16'h0000,16'h0000, 16'h0000,0,4'd14});
        vq.push_back('{0,0,1,4'd3, 0,4'd0,16'h0000,16'h0000, 16'h0000,0,4'd1});
        vq.push_back('{0,0,0,4'd0, 0,4'd0,16'h0000,16'h0000, 16'h0000,1,4'd1});
        vq.push_back('{0,0,0,4'd0, 0,4'd0,16'h0000,16'h0000, 16'h0000,0,4'd1});
        vq.push_back('{0,0,1,4'd14,0,4'd0,16'h0000,16'h0000, 16'h0000,0,4'd15});
        vq.push_back('{0,0,0,4'd0, 0,4'd0,16'h0000,16'h0000, 16'h0000,1,4'd15});
        vq.push_back('{0,0,0,4'd0, 0,4'd0,16'h0000,16'h0000, 16'h0000,0,4'd15});
        vq.push_back('{0,1,0,4'd0, 0,4'd0,16'h0000,16'h0000, 16'h0000,0,4'd0});
        vq.push_back('{0,0,0,4'd0, 0,4'd0,16'h0000,16'h0000, 16'hC123,1,4'd0});
        vq.push_back('{0,0,0,4'd0, 0,4'd0,16'h0000,16'h0000, 16'h0000,0,4'd0});
        vq.push_back('{0,0,1,4'd2, 0,4'd0,16'h0000,16'h0000, 16'h0000,0,4'd2});
        vq.push_back('{0,0,0,4'd0, 0,4'd0,16'h0000,16'h0000, 16'h0000,1,4'd2});
        vq.push_back('{0,0,0,4'd0, 0,4'd0,16'h0000,16'h0000, 16'h0000,0,4'd2});
        vq.push_back('{0,1,1,4'd5, 0,4'd0,16'h0000,16'h0000, 16'h0000,0,4'd7});
        vq.push_back('{0,0,0,4'd0, 1,4'd7,16'hABCD,16'h0000, 16'h0000,1,4'd7});
        vq.push_back('{0,0,0,4'd0, 0,4'd0,16'h0000,16'h0000, 16'h0000,0,4'd7});
        vq.push_back('{0,0,0,4'd0, 0,4'd0,16'h0000,16'h0000, 16'h0000,0,4'd7});
        vq.push_back('{0,0,0,4'd0, 0,4'd0,16'h0000,16'h0000, 16'hABCD,1,4'd7});

        foreach (vq[i]) begin
            interrupt = vq[i].intr; en_cnt = vq[i].cnt; en_offset = vq[i].off;
            pc_offset = vq[i].poff; ins_we = vq[i].we; addr_ins = vq[i].wa;
            io_data = vq[i].wd; io_cmd = vq[i].cmd;
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d.tbl_instr", i), 32'(instructions), 32'(vq[i].e_instr));
            check($sformatf("vec%0d.tbl_issue", i), 32'(issue), 32'(vq[i].e_issue));
            check($sformatf("vec%0d.tbl_pc", i), 32'(pc), 32'(vq[i].e_pc));
        end

        // Interrupt during WAIT at pc=4, memory write while in interrupt, then re-fetch.
        idle_inputs();
        step("irq.wait");
        en_offset = 1; pc_offset = 4'd13;
        step("irq.upd");
        idle_inputs();
        step("irq.issue");
        interrupt = 1; io_cmd = 16'h3A00;
        step("irq.enter");
        check("irq.enter_pc", 32'(pc), 32'd4);
        en_cnt = 1; ins_we = 1; addr_ins = 4'd4; io_data = 16'hD456;
        step("irq.hold");
        check("irq.io_cmd", 32'(instructions), 32'h3A00);
        check("irq.hold_pc", 32'(pc), 32'd4);
        interrupt = 0; en_cnt = 0; ins_we = 0;
        step("irq.exit");
        step("irq.flush");
        check("irq.flush_pass", 32'(instructions), 32'h0);
        step("irq.refetch");
        check("irq.refetch_word", 32'(instructions), 32'hD456);
        check("irq.refetch_issue", 32'(issue), 32'h1);
        check("irq.refetch_pc", 32'(pc), 32'd4);

        // PASS at pc=5 with no feedback: halt loop re-issues every 3 cycles.
        idle_inputs();
        step("halt.wait");
        en_offset = 1; pc_offset = 4'd1;
        step("halt.upd");
        idle_inputs();
        for (int k = 0; k < 9; k++) begin
            step($sformatf("halt%0d", k));
            check($sformatf("halt%0d.pc", k), 32'(pc), 32'd5);
            check($sformatf("halt%0d.issue", k), 32'(issue), (k % 3 == 0) ? 32'd1 : 32'd0);
        end

        // Reset while in UPDATE with en_cnt high, then every word must read back as 0.
        step("mrst.issue");
        step("mrst.wait");
        en_cnt = 1;
        #3;
        do_reset("mrst");
        for (int a = 0; a < 16; a++) begin
            step($sformatf("clr%0d.issue", a));
            check($sformatf("clr%0d.word", a), 32'(instructions), 32'h0);
            step($sformatf("clr%0d.wait", a));
            step($sformatf("clr%0d.upd", a));
        end

        // Random traffic against the model, with interrupt bursts and rare resets.
        intr_left = 0;
        for (int n = 0; n < 2000; n++) begin
            if (intr_left == 0 && $urandom_range(0, 24) == 0) intr_left = $urandom_range(1, 4);
            interrupt = (intr_left > 0);
            if (intr_left > 0) intr_left--;
            en_cnt    = $urandom_range(0, 1);
            en_offset = ($urandom_range(0, 3) == 0);
            pc_offset = 4'($urandom_range(0, 15));
            ins_we    = ($urandom_range(0, 4) == 0);
            addr_ins  = 4'($urandom_range(0, 15));
            io_data   = 16'($urandom);
            io_cmd    = 16'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #2;
                do_reset($sformatf("rnd%0d", n));
                intr_left = 0;
            end
            step($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the controller. It holds the 16-entry instruction memory and the program counter, and drives the registered `instructions` word the controller decodes. It steps the PC from the controller's `en_cnt`, `en_offset` and `pc_offset` feedback, inserting PASS bubbles so that no instruction is decoded twice. During interrupt it forwards IO command words and accepts instruction-memory writes.

## Interface
- `INST_W`, 16: instruction width; opcode is `[15:12]`.
- `PC_W`, 4: PC and instruction-memory address width; depth = 2^PC_W.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `interrupt`  in  1: IO mode request, sampled synchronously.
- `en_cnt`  in  1: controller feedback; PC+1.
- `en_offset`  in  1: controller feedback; relative jump.
- `pc_offset`  in  PC_W: jump distance, unsigned, modulo 2^PC_W.
- `ins_we`  in  1: instruction-memory write enable.
- `addr_ins`  in  PC_W: instruction-memory write address.
- `io_data`  in  INST_W: instruction-memory write data.
- `io_cmd`  in  INST_W: IO command word forwarded during interrupt.
- `instructions`  out  INST_W: registered word to the controller.
- `pc`  out  PC_W: current program counter.
- `issue`  out  1: high for the cycle `instructions` holds a freshly fetched memory word.

## Operation
- States: ISSUE, WAIT, UPDATE, INTR, FLUSH.
- Reset: state ISSUE, `pc`=0, `instructions`=16'h0000 (PASS), `issue`=0, all memory words = 0.
- ISSUE:
  - `instructions` <= imem[pc], `issue` <= 1.
  - Next state WAIT.
- WAIT:
  - `instructions` <= 0, `issue` <= 0.
  - Feedback is ignored; the controller is decoding the issued word.
  - Next state UPDATE.
- UPDATE:
  - `instructions` <= 0.
  - Samples feedback from the issued word: if `en_offset`, pc <= pc + pc_offset; else if `en_cnt`, pc <= pc + 1; else pc holds.
  - Next state ISSUE.
- `en_offset` has priority over `en_cnt` when both are high.
- A PASS in memory produces neither feedback signal, so the PC holds and the same word is re-issued every 3 cycles. This is the halt loop; only interrupt or reset leaves it.
- `interrupt` high in any state:
  - Next state INTR. The in-flight PC update is abandoned and the PC is frozen.
  - In INTR: `instructions` <= io_cmd each cycle, `issue` = 0.
- `interrupt` low while in INTR:
  - Next state FLUSH: `instructions` <= 0 and feedback is ignored.
  - Then ISSUE re-fetches imem[pc], the same PC that was held at interrupt entry.
- Memory write:
  - When `ins_we` is high, imem[addr_ins] <= io_data at the clock edge, in any state.
  - A read of the same address in the same cycle returns the old data (read-first).
- Arithmetic: all PC arithmetic is PC_W bits and wraps (15+1=0, 14+3=1). A backward jump is an offset of 2^PC_W minus the distance.
- Reset mid-operation: reset immediately returns all state and memory to the reset values above.

## Timing
- Normal loop is 3 cycles per instruction: ISSUE -> WAIT -> UPDATE.
  - The word is visible on `instructions` after the ISSUE edge.
  - The controller outputs for that word are valid after the WAIT edge.
  - The PC changes at the UPDATE edge.
  - The next word appears one cycle after that.
- Interrupt:
  - `io_cmd` appears on `instructions` 1 edge after `interrupt` is sampled high.
  - On exit, the first fetched word appears 2 edges after `interrupt` is sampled low (FLUSH, then ISSUE).
- `ins_we` and `io_data` land in memory at the same edge they are sampled. A write followed by a fetch of that address in a later cycle returns the new data.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

## Structure
- Shared definitions include file:
  - `BIT_INST` and `SZB_INS` widths.
  - Opcode constants.
  - PASS word (16'h0000).
  - fetch state encodings (3-bit).
- One sub-module, `imem_rf`: a 2^PC_W x INST_W register file with asynchronous clear, synchronous write port and asynchronous read port.
- `fetch_unit` holds the FSM, the PC, and the `instructions` / `issue` registers.

## Test plan
- Reset, preload imem[0]=16'hC123 (ADD), hold `en_cnt` pulse in UPDATE -> `instructions`=16'hC123 with `issue`=1 on cycle 1, PASS on cycles 2–3, `pc`=1 after cycle 3.
- pc=14, `en_offset`=1, `pc_offset`=3 in UPDATE -> `pc`=1 (wrap). `en_cnt`=1 at pc=15 -> `pc`=0.
- `en_offset` and `en_cnt` both high in UPDATE at pc=2, `pc_offset`=5 -> `pc`=7.
- Assert `interrupt` during WAIT at pc=4 with `io_cmd`=16'h3A00 -> `instructions`=16'h3A00 next cycle and `pc` stays 4. During interrupt, `ins_we`=1, `addr_ins`=4, `io_data`=16'hD456. Deassert `interrupt` -> one PASS cycle, then `instructions`=16'hD456 with `issue`=1.
- imem[5]=PASS at pc=5, no feedback -> 16'h0000 re-issued every 3 cycles with `pc`=5 indefinitely.
- Assert `reset` in UPDATE with `en_cnt`=1 -> `pc`=0, `instructions`=0, `issue`=0, all memory words read 0.
